// File: rtl/usb_crc_tx_ctrl.sv
// -----------------------------------------------------------------------------
// usb_crc_tx_ctrl
//
// Transmit-side sequencer for USB packet CRC generation. Takes a packet request
// (PID) plus an upstream byte stream. It prepends the PID byte, drives the
// external CRC5/CRC16 engines and the one-hot CRC mux select, and appends the
// inverted CRC field. Every outgoing byte passes through a single-entry output
// register.
//
// Parameters
//   CRC_LAT      cycles from an engine strobe to a valid mux result (1..4)
//   MAX_PAYLOAD  largest data payload that is emitted and CRC'd
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   pkt_start_i, pid_i, zlp_i  packet request (sampled only in IDLE)
//   data_i, data_valid_i,
//   data_last_i, data_ready_o  upstream payload / token-field byte stream
//   crc_clr_o, crc5_upd_o,
//   crc16_upd_o, crc_data_o    CRC engine control and data
//   sel_o                      CRC mux select: 001 CRC5, 010 CRC16, 100 none
//   crc5_i, crc16_i            CRC results from the mux
//   tx_data_o, tx_valid_o,
//   tx_ready_i, tx_last_o      downstream byte interface to the serializer
//   busy_o                     packet in progress
//   ovf_o                      sticky payload overflow, cleared on next start
// -----------------------------------------------------------------------------
module usb_crc_tx_ctrl #(
    parameter int unsigned CRC_LAT     = 1,
    parameter int unsigned MAX_PAYLOAD = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pkt_start_i,
    input  logic [3:0]  pid_i,
    input  logic        zlp_i,
    input  logic [7:0]  data_i,
    input  logic        data_valid_i,
    input  logic        data_last_i,
    output logic        data_ready_o,
    output logic        crc_clr_o,
    output logic        crc5_upd_o,
    output logic        crc16_upd_o,
    output logic [10:0] crc_data_o,
    output logic [2:0]  sel_o,
    input  logic [4:0]  crc5_i,
    input  logic [15:0] crc16_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        tx_last_o,
    output logic        busy_o,
    output logic        ovf_o
);

    localparam int unsigned    CW      = $clog2(MAX_PAYLOAD + 1);
    localparam logic [2:0]     LAT     = 3'(CRC_LAT);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_PAYLOAD);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PID,
        S_TOK_COL,
        S_TOK_WAIT,
        S_TOK_B1,
        S_TOK_B2,
        S_DAT,
        S_DAT_WAIT,
        S_CRC_LO,
        S_CRC_HI
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    pid_q, pid_d;
    logic          zlp_q, zlp_d;
    logic [10:0]   field_q, field_d;
    logic          byte1_q, byte1_d;   // token field: next byte is byte1
    logic          sent_q, sent_d;     // final byte loaded, waiting for accept
    logic [4:0]    crc5_q, crc5_d;
    logic [15:0]   crc16_q, crc16_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    lat_q, lat_d;       // cycles since last engine strobe, saturating
    logic          ovf_q, ovf_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_last_q, tx_last_d;

    logic          load;
    logic [7:0]    load_data;
    logic          load_last;

    logic is_tok;
    logic is_dat;
    logic tx_free;
    logic tx_fire;

    assign is_tok  = (pid_q[1:0] == 2'b01);
    assign is_dat  = (pid_q[1:0] == 2'b11);
    assign tx_free = !tx_valid_q || tx_ready_i;
    assign tx_fire = tx_valid_q && tx_ready_i;

    // NOTE: every signal written here gets a default before the case so that no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d      = state_q;
        pid_d        = pid_q;
        zlp_d        = zlp_q;
        field_d      = field_q;
        byte1_d      = byte1_q;
        sent_d       = sent_q;
        crc5_d       = crc5_q;
        crc16_d      = crc16_q;
        cnt_d        = cnt_q;
        lat_d        = lat_q;
        ovf_d        = ovf_q;
        tx_data_d    = tx_data_q;
        tx_last_d    = tx_last_q;
        tx_valid_d   = tx_valid_q && !tx_ready_i;
        load         = 1'b0;
        load_data    = '0;
        load_last    = 1'b0;
        data_ready_o = 1'b0;
        crc_clr_o    = 1'b0;
        crc5_upd_o   = 1'b0;
        crc16_upd_o  = 1'b0;
        crc_data_o   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (pkt_start_i) begin
                    pid_d     = pid_i;
                    zlp_d     = zlp_i;
                    crc_clr_o = 1'b1;
                    ovf_d     = 1'b0;
                    cnt_d     = '0;
                    byte1_d   = 1'b0;
                    sent_d    = 1'b0;
                    state_d   = S_PID;
                end
            end

            S_PID: begin
                if (!is_tok && !is_dat) begin
                    // Handshake/special: the PID byte is the whole packet.
                    if (!sent_q && tx_free) begin
                        load      = 1'b1;
                        load_data = {~pid_q, pid_q};
                        load_last = 1'b1;
                        sent_d    = 1'b1;
                    end else if (sent_q && tx_fire) begin
                        sent_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (tx_free) begin
                    load      = 1'b1;
                    load_data = {~pid_q, pid_q};
                    if (is_tok)     state_d = S_TOK_COL;
                    else if (zlp_q) state_d = S_DAT_WAIT;
                    else            state_d = S_DAT;
                end
            end

            S_TOK_COL: begin
                // The field is held internally, so collection never stalls.
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    if (!byte1_q) begin
                        field_d[7:0] = data_i;
                        byte1_d      = 1'b1;
                    end else begin
                        field_d[10:8] = data_i[2:0];
                        crc5_upd_o    = 1'b1;
                        crc_data_o    = {data_i[2:0], field_q[7:0]};
                        byte1_d       = 1'b0;
                        state_d       = S_TOK_WAIT;
                    end
                end
            end

            S_TOK_WAIT: begin
                if (lat_q >= LAT) begin
                    crc5_d  = crc5_i;
                    state_d = S_TOK_B1;
                end
            end

            S_TOK_B1: begin
                if (tx_free) begin
                    load      = 1'b1;
                    load_data = field_q[7:0];
                    state_d   = S_TOK_B2;
                end
            end

            S_DAT: begin
                data_ready_o = tx_free;
                if (data_valid_i && tx_free) begin
                    if (cnt_q == CNT_MAX) begin
                        // Excess bytes are swallowed so upstream can still finish.
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d       = cnt_q + CW'(1);
                        crc16_upd_o = 1'b1;
                        crc_data_o  = {3'b000, data_i};
                        load        = 1'b1;
                        load_data   = data_i;
                    end
                    if (data_last_i) state_d = S_DAT_WAIT;
                end
            end

            S_DAT_WAIT: begin
                if ((lat_q >= LAT) && tx_free) begin
                    crc16_d = crc16_i;
                    state_d = S_CRC_LO;
                end
            end

            S_CRC_LO: begin
                if (tx_free) begin
                    load      = 1'b1;
                    load_data = ~crc16_q[7:0];
                    state_d   = S_CRC_HI;
                end
            end

            S_TOK_B2, S_CRC_HI: begin
                // Stay until the final byte has actually left, so busy_o covers it.
                if (!sent_q && tx_free) begin
                    load      = 1'b1;
                    load_data = (state_q == S_TOK_B2) ? {~crc5_q, field_q[10:8]}
                                                      : ~crc16_q[15:8];
                    load_last = 1'b1;
                    sent_d    = 1'b1;
                end else if (sent_q && tx_fire) begin
                    sent_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (crc_clr_o || crc5_upd_o || crc16_upd_o) lat_d = 3'd1;
        else if (lat_q < LAT)                       lat_d = lat_q + 3'd1;

        if (load) begin
            tx_valid_d = 1'b1;
            tx_data_d  = load_data;
            tx_last_d  = load_last;
        end
    end

    always_comb begin
        sel_o = 3'b100;
        if (state_q != S_IDLE) begin
            if (is_tok)      sel_o = 3'b001;
            else if (is_dat) sel_o = 3'b010;
        end
    end

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the pre-edge value of every other flop, matching the hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pid_q      <= '0;
            zlp_q      <= 1'b0;
            field_q    <= '0;
            byte1_q    <= 1'b0;
            sent_q     <= 1'b0;
            crc5_q     <= '0;
            crc16_q    <= '0;
            cnt_q      <= '0;
            lat_q      <= '0;
            ovf_q      <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pid_q      <= pid_d;
            zlp_q      <= zlp_d;
            field_q    <= field_d;
            byte1_q    <= byte1_d;
            sent_q     <= sent_d;
            crc5_q     <= crc5_d;
            crc16_q    <= crc16_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            ovf_q      <= ovf_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign tx_last_o  = tx_last_q;
    assign busy_o     = (state_q != S_IDLE);
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_usb_crc_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_usb_crc_tx_ctrl
//
// Scoreboard bench for usb_crc_tx_ctrl. Expected tx bytes and engine strobe
// data are queued when a packet is driven and are compared as the DUT emits
// them. A small CRC engine model with CRC_LAT latency returns chosen results.
// The model yields distinct junk values before the final update, so a result
// captured too early shows up as a wrong CRC byte.
// -----------------------------------------------------------------------------
module tb_usb_crc_tx_ctrl;

    localparam int unsigned CRC_LAT     = 2;
    localparam int unsigned MAX_PAYLOAD = 4;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pkt_start_i = 1'b0;
    logic [3:0]  pid_i = '0;
    logic        zlp_i = 1'b0;
    logic [7:0]  data_i = '0;
    logic        data_valid_i = 1'b0;
    logic        data_last_i = 1'b0;
    logic        data_ready_o;
    logic        crc_clr_o;
    logic        crc5_upd_o;
    logic        crc16_upd_o;
    logic [10:0] crc_data_o;
    logic [2:0]  sel_o;
    logic [4:0]  crc5_i;
    logic [15:0] crc16_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b1;
    logic        tx_last_o;
    logic        busy_o;
    logic        ovf_o;

    always #5 clk = ~clk;

    usb_crc_tx_ctrl #(
        .CRC_LAT    (CRC_LAT),
        .MAX_PAYLOAD(MAX_PAYLOAD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pkt_start_i (pkt_start_i),
        .pid_i       (pid_i),
        .zlp_i       (zlp_i),
        .data_i      (data_i),
        .data_valid_i(data_valid_i),
        .data_last_i (data_last_i),
        .data_ready_o(data_ready_o),
        .crc_clr_o   (crc_clr_o),
        .crc5_upd_o  (crc5_upd_o),
        .crc16_upd_o (crc16_upd_o),
        .crc_data_o  (crc_data_o),
        .sel_o       (sel_o),
        .crc5_i      (crc5_i),
        .crc16_i     (crc16_i),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .tx_last_o   (tx_last_o),
        .busy_o      (busy_o),
        .ovf_o       (ovf_o)
    );

    int errors = 0;
    int checks = 0;

    logic [8:0]  exp_q[$];     // {last, byte}
    logic [10:0] exp5_q[$];
    logic [7:0]  exp16_q[$];
    int          n5 = 0;
    int          n16 = 0;
    logic [2:0]  sel_or = '0;
    logic        ready_toggle = 1'b0;
    bq_t         pay;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // CRC engine + mux model: one update stage plus one mux stage (CRC_LAT=2).
    logic [4:0]  tgt5 = '0;
    logic [15:0] tgt16 = '0;
    int          tgt16_n = 0;
    logic [4:0]  e5 = 5'h1F;
    logic [4:0]  m5 = 5'h1F;
    logic [15:0] e16 = 16'hFFFF;
    logic [15:0] m16 = 16'hFFFF;
    int          u16 = 0;

    always @(posedge clk) begin
        if (crc_clr_o) begin
            e5  <= 5'h1F;
            e16 <= 16'hFFFF;
            u16 <= 0;
        end else begin
            if (crc5_upd_o) e5 <= tgt5;
            if (crc16_upd_o) begin
                u16 <= u16 + 1;
                e16 <= (u16 + 1 == tgt16_n) ? tgt16 : (16'hA500 ^ 16'(u16));
            end
        end
        m5  <= e5;
        m16 <= e16;
    end

    assign crc5_i  = m5;
    assign crc16_i = m16;

    // Downstream ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_ready_i = ready_toggle ? ~tx_ready_i : 1'b1;
        end
    end

    // Monitor: samples at the falling edge, away from the active edge.
    logic       stall_prev = 1'b0;
    logic [8:0] held = '0;
    logic [8:0] e_byte;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (busy_o) sel_or = sel_or | sel_o;
                if (stall_prev)
                    check("tx_hold", {tx_valid_o, tx_last_o, tx_data_o}, {1'b1, held});
                if (tx_valid_o && tx_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("tx_extra", {tx_last_o, tx_data_o}, 32'h200);
                    end else begin
                        e_byte = exp_q.pop_front();
                        check("tx_byte", {tx_last_o, tx_data_o}, e_byte);
                    end
                end
                stall_prev = tx_valid_o && !tx_ready_i;
                held       = {tx_last_o, tx_data_o};
                if (crc5_upd_o) begin
                    n5++;
                    if (exp5_q.size() == 0) check("crc5_extra", crc_data_o, 32'h800);
                    else                    check("crc5_data", crc_data_o, exp5_q.pop_front());
                end
                if (crc16_upd_o) begin
                    n16++;
                    if (exp16_q.size() == 0) check("crc16_extra", crc_data_o, 32'h800);
                    else                     check("crc16_data", crc_data_o, {3'b000, exp16_q.pop_front()});
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic start_pkt(input logic [3:0] pid, input logic zlp);
        sel_or      = '0;
        pkt_start_i = 1'b1;
        pid_i       = pid;
        zlp_i       = zlp;
        @(posedge clk);
        #1;
        pkt_start_i = 1'b0;
        zlp_i       = 1'b0;
    endtask

    // Drives bytes with valid held until accepted; counts stall cycles after
    // the first accept.
    task automatic send_bytes(input bq_t bytes, input bit mark_last, output int bubbles);
        int  budget;
        bit  started;
        bit  ok;
        started = 1'b0;
        bubbles = 0;
        foreach (bytes[i]) begin
            data_valid_i = 1'b1;
            data_i       = bytes[i];
            data_last_i  = mark_last && (i == bytes.size() - 1);
            budget       = 0;
            ok           = 1'b0;
            while (!ok && budget < 100) begin
                #3;
                if (data_ready_o) begin
                    ok      = 1'b1;
                    started = 1'b1;
                end else begin
                    if (started) bubbles++;
                    budget++;
                end
                @(posedge clk);
                #1;
            end
            if (!ok) begin
                check("in_timeout", budget, 0);
                break;
            end
        end
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((busy_o || exp_q.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_timeout", (n >= 300), 0);
    endtask

    task automatic run_data(input string tag, input logic [3:0] pid, input logic [7:0] pid_byte,
                            input bq_t bytes, input logic [15:0] crc, input bit zlp,
                            input bit toggle, input logic exp_ovf);
        int s16;
        int ncrc;
        int bub;
        s16  = n16;
        ncrc = (bytes.size() < MAX_PAYLOAD) ? bytes.size() : MAX_PAYLOAD;
        tgt16   = crc;
        tgt16_n = zlp ? 0 : ncrc;
        exp_q.push_back({1'b0, pid_byte});
        for (int i = 0; i < ncrc; i++) begin
            exp_q.push_back({1'b0, bytes[i]});
            exp16_q.push_back(bytes[i]);
        end
        exp_q.push_back({1'b0, ~crc[7:0]});
        exp_q.push_back({1'b1, ~crc[15:8]});
        ready_toggle = toggle;
        start_pkt(pid, zlp);
        bub = 0;
        if (!zlp) send_bytes(bytes, 1'b1, bub);
        wait_done();
        ready_toggle = 1'b0;
        check({tag, "_n16"}, n16 - s16, zlp ? 0 : ncrc);
        check({tag, "_sel"}, sel_or[1:0], 2'b10);
        check({tag, "_ovf"}, ovf_o, exp_ovf);
        check({tag, "_busy"}, busy_o, 0);
        if (!toggle && !zlp) check({tag, "_bubble"}, bub, 0);
    endtask

    int s5;
    int s16;
    int bub;

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {data_ready_o, crc_clr_o, crc5_upd_o, crc16_upd_o, crc_data_o,
                           tx_data_o, tx_valid_o, tx_last_o, busy_o, ovf_o}, 0);
        check("rst_sel", sel_o, 3'b100);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ACK handshake: single byte 0xD2, no engine activity.
        s5  = n5;
        s16 = n16;
        exp_q.push_back({1'b1, 8'hD2});
        start_pkt(4'h2, 1'b0);
        wait_done();
        check("ack_sel", sel_or, 3'b100);
        check("ack_strobes", (n5 - s5) + (n16 - s16), 0);
        check("ack_busy", busy_o, 0);

        // IN token.
        s5   = n5;
        s16  = n16;
        tgt5 = 5'h17;
        exp5_q.push_back(11'h715);
        exp_q.push_back({1'b0, 8'h69});
        exp_q.push_back({1'b0, 8'h15});
        exp_q.push_back({1'b1, 8'h47});
        start_pkt(4'h9, 1'b0);
        pay = '{8'h15, 8'h07};
        send_bytes(pay, 1'b1, bub);
        wait_done();
        check("in_n5", n5 - s5, 1);
        check("in_n16", n16 - s16, 0);
        check("in_sel", sel_or[1:0], 2'b01);

        // DATA0, full throughput, then with backpressure.
        pay = '{8'h00, 8'h01, 8'h02, 8'h03};
        run_data("dat0", 4'h3, 8'hC3, pay, 16'h2B7A, 1'b0, 1'b0, 1'b0);
        run_data("bp",   4'h3, 8'hC3, pay, 16'h2B7A, 1'b0, 1'b1, 1'b0);

        // Zero-length DATA1: CRC of the cleared engine.
        pay = '{};
        run_data("zlp", 4'hB, 8'h4B, pay, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        // Overflow: 6 bytes against MAX_PAYLOAD=4.
        pay = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        run_data("ovf", 4'h3, 8'hC3, pay, 16'h1234, 1'b0, 1'b0, 1'b1);

        // Mid-payload reset; ovf_o must clear on the accepted start.
        tgt16   = 16'h0000;
        tgt16_n = 99;
        exp_q.push_back({1'b0, 8'hC3});
        exp_q.push_back({1'b0, 8'hAA});
        exp_q.push_back({1'b0, 8'hBB});
        exp16_q.push_back(8'hAA);
        exp16_q.push_back(8'hBB);
        start_pkt(4'h3, 1'b0);
        check("ovf_clr", ovf_o, 0);
        pay = '{8'hAA, 8'hBB};
        send_bytes(pay, 1'b0, bub);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_outs", {data_ready_o, crc_clr_o, crc5_upd_o, crc16_upd_o, crc_data_o,
                              tx_data_o, tx_valid_o, tx_last_o, busy_o, ovf_o}, 0);
        check("rstmid_sel", sel_o, 3'b100);
        exp_q.delete();
        exp16_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        pay = '{8'h00, 8'h01, 8'h02, 8'h03};
        run_data("post", 4'h3, 8'hC3, pay, 16'h2B7A, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
